// File: rtl/pc_unit_if.sv
// Fetch-stage PC bus: control/target inputs toward the PC unit and the PC,
// advance counter and return-address-stack views coming back from it.
interface pc_unit_if #(
  parameter int NBITS = 32
);
  logic             i_enable;
  logic             i_step;
  logic             i_stall;
  logic             i_halt;
  logic             i_Jump;
  logic             i_JAL;
  logic             i_JALR;
  logic [NBITS-1:0] i_rs;
  logic             i_pcSrc;
  logic [NBITS-1:0] i_SumadorBranch;
  logic [NBITS-1:0] i_SumadorJump;
  logic [NBITS-1:0] i_ret_addr;
  logic [NBITS-1:0] o_pc;
  logic [NBITS-1:0] o_pc4;
  logic             o_halted;
  logic [NBITS-1:0] o_adv_cnt;
  logic [NBITS-1:0] o_ras_top;
  logic             o_ras_valid;
  logic             o_ras_overflow;

  // Side that drives control and targets (debug unit / decode / bench).
  modport master (
    output i_enable, i_step, i_stall, i_halt, i_Jump, i_JAL, i_JALR,
           i_rs, i_pcSrc, i_SumadorBranch, i_SumadorJump, i_ret_addr,
    input  o_pc, o_pc4, o_halted, o_adv_cnt, o_ras_top, o_ras_valid,
           o_ras_overflow
  );

  // The PC unit itself.
  modport slave (
    input  i_enable, i_step, i_stall, i_halt, i_Jump, i_JAL, i_JALR,
           i_rs, i_pcSrc, i_SumadorBranch, i_SumadorJump, i_ret_addr,
    output o_pc, o_pc4, o_halted, o_adv_cnt, o_ras_top, o_ras_valid,
           o_ras_overflow
  );
endinterface

// File: rtl/pc_unit.sv
// Registered program counter for the fetch path: priority next-PC select
// (jump > jalr > branch > sequential), stall, sticky halt, debug run/step,
// advance counter and a circular return-address stack for return prediction.
module pc_unit #(
  parameter int               NBITS     = 32,
  parameter logic [NBITS-1:0] RESET_PC  = '0,
  parameter int               PC_STEP   = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_reset,
  pc_unit_if.slave bus
);

  localparam int              PW      = $clog2(RAS_DEPTH);
  localparam int              CW      = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(RAS_DEPTH);

  // Stack occupancy saturates at the depth; further pushes overwrite the oldest.
  function automatic logic [CW-1:0] ras_cnt_inc(input logic [CW-1:0] c);
    return (c == DEPTH_C) ? c : c + CW'(1);
  endfunction

  // Pops on an empty stack leave the count at zero.
  function automatic logic [CW-1:0] ras_cnt_dec(input logic [CW-1:0] c);
    return (c == '0) ? c : c - CW'(1);
  endfunction

  logic [NBITS-1:0] pc_p0;
  logic             halted_p0;
  logic [NBITS-1:0] adv_cnt_p0;
  logic [NBITS-1:0] ras_mem_p0 [RAS_DEPTH];
  logic [PW-1:0]    ras_wr_p0;
  logic [CW-1:0]    ras_cnt_p0;
  logic             ras_ovf_p0;

  logic             adv;
  logic             do_adv;
  logic             push;
  logic             pop;
  logic [NBITS-1:0] pc4;
  logic [NBITS-1:0] pc_next;
  logic [PW-1:0]    ras_top_idx;

  assign adv    = ~halted_p0 & ~bus.i_stall & (bus.i_enable | bus.i_step);
  assign do_adv = adv & ~bus.i_halt;
  // JAL only links when the jump itself is taken; JALR pops only when not
  // overridden by a jump.
  assign push   = bus.i_Jump & bus.i_JAL;
  assign pop    = bus.i_JALR & ~bus.i_Jump;
  assign pc4    = pc_p0 + NBITS'(PC_STEP);

  // Fixed-priority next-PC select.
  always_comb begin
    pc_next = pc4;
    if (bus.i_Jump)       pc_next = bus.i_SumadorJump;
    else if (bus.i_JALR)  pc_next = bus.i_rs;
    else if (bus.i_pcSrc) pc_next = bus.i_SumadorBranch;
  end

  // ---- stage p0: PC, sticky halt and advance counter ----
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_p0      <= RESET_PC;
      halted_p0  <= 1'b0;
      adv_cnt_p0 <= '0;
    end else if (adv) begin
      if (bus.i_halt) begin
        halted_p0 <= 1'b1;
      end else begin
        pc_p0      <= pc_next;
        adv_cnt_p0 <= adv_cnt_p0 + NBITS'(1);
      end
    end
  end

  // Return-address stack: ras_wr_p0 is the slot the next push writes, so the
  // top lives one slot behind it; the pointer wraps since depth is a power of two.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem_p0[i] <= '0;
      ras_wr_p0  <= '0;
      ras_cnt_p0 <= '0;
      ras_ovf_p0 <= 1'b0;
    end else if (do_adv) begin
      if (push) begin
        ras_mem_p0[ras_wr_p0] <= bus.i_ret_addr;
        ras_wr_p0             <= ras_wr_p0 + PW'(1);
        ras_cnt_p0            <= ras_cnt_inc(ras_cnt_p0);
        if (ras_cnt_p0 == DEPTH_C) ras_ovf_p0 <= 1'b1;
      end else if (pop && ras_cnt_p0 != '0) begin
        ras_wr_p0  <= ras_wr_p0 - PW'(1);
        ras_cnt_p0 <= ras_cnt_dec(ras_cnt_p0);
      end
    end
  end

  assign ras_top_idx        = ras_wr_p0 - PW'(1);

  assign bus.o_pc           = pc_p0;
  assign bus.o_pc4          = pc4;
  assign bus.o_halted       = halted_p0;
  assign bus.o_adv_cnt      = adv_cnt_p0;
  assign bus.o_ras_valid    = (ras_cnt_p0 != '0);
  assign bus.o_ras_top      = (ras_cnt_p0 != '0) ? ras_mem_p0[ras_top_idx] : '0;
  assign bus.o_ras_overflow = ras_ovf_p0;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, select priority, stall/step, halt,
// return-address stack and wrap-around, with a small 8-bit build for counter wrap.
module tb_pc_unit;

  logic clk;
  logic rst_n;
  logic rst_n_b;
  int   total;
  int   bad;

  pc_unit_if #(.NBITS(32)) bus ();
  pc_unit_if #(.NBITS(8))  bus_b ();

  pc_unit #(
    .NBITS(32), .RESET_PC(32'h100), .PC_STEP(4), .RAS_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .bus(bus)
  );

  pc_unit #(
    .NBITS(8), .RESET_PC(8'h00), .PC_STEP(4), .RAS_DEPTH(2)
  ) dut_b (
    .i_clk(clk), .i_reset(rst_n_b), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    bus.i_enable = 1'b0; bus.i_step = 1'b0; bus.i_stall = 1'b0; bus.i_halt = 1'b0;
    bus.i_Jump = 1'b0; bus.i_JAL = 1'b0; bus.i_JALR = 1'b0; bus.i_pcSrc = 1'b0;
    bus.i_rs = '0; bus.i_SumadorBranch = '0; bus.i_SumadorJump = '0; bus.i_ret_addr = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n   = 1'b0;
    rst_n_b = 1'b0;
    clear_ctl();
    bus_b.i_enable = 1'b1; bus_b.i_step = 1'b0; bus_b.i_stall = 1'b0; bus_b.i_halt = 1'b0;
    bus_b.i_Jump = 1'b0; bus_b.i_JAL = 1'b0; bus_b.i_JALR = 1'b0; bus_b.i_pcSrc = 1'b0;
    bus_b.i_rs = '0; bus_b.i_SumadorBranch = '0; bus_b.i_SumadorJump = '0; bus_b.i_ret_addr = '0;

    // Reset state
    tick();
    chk("rst_pc", bus.o_pc, 32'h100);
    chk("rst_pc4", bus.o_pc4, 32'h104);
    chk("rst_cnt", bus.o_adv_cnt, 32'h0);
    chk("rst_halted", {31'b0, bus.o_halted}, 32'h0);
    chk("rst_ras_valid", {31'b0, bus.o_ras_valid}, 32'h0);
    chk("rst_ras_top", bus.o_ras_top, 32'h0);
    chk("rst_ras_ovf", {31'b0, bus.o_ras_overflow}, 32'h0);

    // Priority: jump > jalr > branch > sequential
    rst_n = 1'b1;
    bus.i_enable = 1'b1;
    bus.i_Jump = 1'b1; bus.i_JALR = 1'b1; bus.i_pcSrc = 1'b1;
    bus.i_SumadorJump = 32'h400; bus.i_rs = 32'h800; bus.i_SumadorBranch = 32'h200;
    tick();
    chk("prio_jump", bus.o_pc, 32'h400);
    bus.i_Jump = 1'b0;
    tick();
    chk("prio_jalr", bus.o_pc, 32'h800);
    chk("pop_empty_valid", {31'b0, bus.o_ras_valid}, 32'h0);
    bus.i_JALR = 1'b0;
    tick();
    chk("prio_branch", bus.o_pc, 32'h200);
    bus.i_pcSrc = 1'b0;
    tick();
    chk("prio_seq", bus.o_pc, 32'h204);
    chk("prio_cnt", bus.o_adv_cnt, 32'd4);

    // Stall freezes everything
    bus.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", bus.o_pc, 32'h204);
      chk("stall_cnt", bus.o_adv_cnt, 32'd4);
    end
    bus.i_stall = 1'b0;

    // Debug single-step
    bus.i_enable = 1'b0;
    tick();
    chk("dbg_hold_pc", bus.o_pc, 32'h204);
    bus.i_step = 1'b1;
    tick();
    bus.i_step = 1'b0;
    tick();
    chk("step1_pc", bus.o_pc, 32'h208);
    bus.i_step = 1'b1;
    tick();
    bus.i_step = 1'b0;
    tick();
    chk("step2_pc", bus.o_pc, 32'h20C);
    chk("step2_cnt", bus.o_adv_cnt, 32'd6);
    bus.i_step = 1'b1; bus.i_stall = 1'b1;
    tick();
    chk("step_stall_pc", bus.o_pc, 32'h20C);
    chk("step_stall_cnt", bus.o_adv_cnt, 32'd6);
    bus.i_step = 1'b0; bus.i_stall = 1'b0;

    // Asynchronous reset mid-cycle at pc=0x120
    bus.i_enable = 1'b1; bus.i_Jump = 1'b1; bus.i_SumadorJump = 32'h11C;
    tick();
    bus.i_Jump = 1'b0;
    tick();
    chk("pre_async_pc", bus.o_pc, 32'h120);
    bus.i_enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", bus.o_pc, 32'h100);
    chk("async_rst_cnt", bus.o_adv_cnt, 32'h0);

    // Release with no dead cycle
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_enable = 1'b1;
    tick();
    chk("release_pc", bus.o_pc, 32'h104);

    // Halt at 0x10
    bus.i_Jump = 1'b1; bus.i_SumadorJump = 32'h0C;
    tick();
    bus.i_Jump = 1'b0;
    tick();
    chk("pre_halt_pc", bus.o_pc, 32'h10);
    bus.i_halt = 1'b1;
    tick();
    chk("halt_pc", bus.o_pc, 32'h10);
    chk("halt_flag", {31'b0, bus.o_halted}, 32'h1);
    chk("halt_cnt", bus.o_adv_cnt, 32'd3);
    bus.i_halt = 1'b0;
    bus.i_Jump = 1'b1; bus.i_JAL = 1'b1; bus.i_SumadorJump = 32'h500; bus.i_ret_addr = 32'h55;
    tick();
    tick();
    chk("halted_pc", bus.o_pc, 32'h10);
    chk("halted_flag", {31'b0, bus.o_halted}, 32'h1);
    chk("halted_ras", {31'b0, bus.o_ras_valid}, 32'h0);
    chk("halted_cnt", bus.o_adv_cnt, 32'd3);
    rst_n = 1'b0;
    tick();
    chk("halt_clear", {31'b0, bus.o_halted}, 32'h0);
    rst_n = 1'b1;
    clear_ctl();

    // RAS: 5 pushes into a 4-deep stack
    bus.i_enable = 1'b1; bus.i_Jump = 1'b1; bus.i_JAL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.i_SumadorJump = 32'h1000 + 32'(i * 16);
      bus.i_ret_addr = 32'hA0 + 32'(i);
      tick();
      if (i == 3) chk("ras_full_no_ovf", {31'b0, bus.o_ras_overflow}, 32'h0);
    end
    chk("ras_push_top", bus.o_ras_top, 32'hA4);
    chk("ras_push_ovf", {31'b0, bus.o_ras_overflow}, 32'h1);
    chk("ras_push_valid", {31'b0, bus.o_ras_valid}, 32'h1);
    bus.i_Jump = 1'b0; bus.i_JAL = 1'b0; bus.i_JALR = 1'b1; bus.i_rs = 32'h3000;
    tick();
    chk("ras_pop1", bus.o_ras_top, 32'hA3);
    tick();
    chk("ras_pop2", bus.o_ras_top, 32'hA2);
    tick();
    chk("ras_pop3", bus.o_ras_top, 32'hA1);
    tick();
    chk("ras_pop4_valid", {31'b0, bus.o_ras_valid}, 32'h0);
    chk("ras_pop4_top", bus.o_ras_top, 32'h0);
    tick();
    chk("ras_pop5_valid", {31'b0, bus.o_ras_valid}, 32'h0);
    chk("ras_pop5_ovf", {31'b0, bus.o_ras_overflow}, 32'h1);
    chk("ras_pop5_pc", bus.o_pc, 32'h3000);
    bus.i_JALR = 1'b0; bus.i_JAL = 1'b1; bus.i_ret_addr = 32'hBB;
    tick();
    chk("jal_no_jump", {31'b0, bus.o_ras_valid}, 32'h0);
    bus.i_JAL = 1'b0;

    // PC wrap
    bus.i_Jump = 1'b1; bus.i_SumadorJump = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pc_top", bus.o_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", bus.o_pc4, 32'h0);
    bus.i_Jump = 1'b0;
    tick();
    chk("wrap_pc", bus.o_pc, 32'h0);

    // Advance counter wrap on the 8-bit build
    @(negedge clk);
    rst_n_b = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    chk("b_cnt_max", {24'b0, bus_b.o_adv_cnt}, 32'hFF);
    chk("b_pc", {24'b0, bus_b.o_pc}, 32'hFC);
    tick();
    chk("b_cnt_wrap", {24'b0, bus_b.o_adv_cnt}, 32'h0);
    chk("b_pc_wrap", {24'b0, bus_b.o_pc}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Registered program-counter stage for the MIPS fetch path; the next generation of the combinational next-PC select.
- Holds the PC and computes next PC with fixed priority: jump > jalr > branch > sequential.
- Adds stall, sticky halt, debug run/single-step control, an advance counter, and a parametrised return-address stack (RAS) that fetch uses for early return prediction.

Parameters:
NBITS, 32, datapath/address width.
RESET_PC, 0, PC value loaded on reset.
PC_STEP, 4, sequential increment in bytes.
RAS_DEPTH, 4, return-address stack entries (power of two, >=2).

Ports:
i_clk  in  1  clock, all state updates on rising edge.
i_reset  in  1  asynchronous, active-low reset.
i_enable  in  1  debug run mode; 1 = free-running advance.
i_step  in  1  single-step pulse; honoured only while i_enable=0.
i_stall  in  1  pipeline stall (hazard unit); blocks advance.
i_halt  in  1  halt instruction present at the current advance.
i_Jump  in  1  J/JAL taken.
i_JAL  in  1  link qualifier; a push occurs only with i_Jump.
i_JALR  in  1  JR/JALR taken.
i_rs  in  NBITS  register target for JR/JALR.
i_pcSrc  in  1  branch taken.
i_SumadorBranch  in  NBITS  branch target.
i_SumadorJump  in  NBITS  jump target.
i_ret_addr  in  NBITS  link address to push on JAL.
o_pc  out  NBITS  current PC.
o_pc4  out  NBITS  o_pc + PC_STEP, combinational, wraps mod 2^NBITS.
o_halted  out  1  sticky halt flag.
o_adv_cnt  out  NBITS  number of PC advances since reset, wraps.
o_ras_top  out  NBITS  top-of-stack address (0 when empty).
o_ras_valid  out  1  stack non-empty.
o_ras_overflow  out  1  sticky; set when a push overwrites the oldest entry.

Behaviour:
- Reset (asynchronous, i_reset=0): o_pc=RESET_PC, o_halted=0, o_adv_cnt=0, stack count=0, all entries=0, o_ras_valid=0, o_ras_overflow=0, o_ras_top=0.
- Reset release mid-operation: the first edge with i_reset=1 is a normal cycle; there is no dead cycle.
- Advance condition: adv = ~o_halted & ~i_stall & (i_enable | i_step).
- i_step is edge-agnostic: each cycle it is high while i_enable=0 and the other conditions hold is one advance. The debug unit supplies one-cycle pulses.
- Next PC (used only when adv): i_Jump ? i_SumadorJump : i_JALR ? i_rs : i_pcSrc ? i_SumadorBranch : o_pc4.
- Next PC is registered: o_pc updates on the edge where adv=1. Latency is 1 cycle from the select inputs to o_pc.
- Halt: adv & i_halt means o_pc holds, o_halted goes to 1 on that edge, o_adv_cnt does not increment, and the RAS is unchanged. The flag clears only on reset.
- o_adv_cnt increments by 1 on every edge with adv & ~i_halt; it wraps from 2^NBITS-1 to 0.
- When adv=0, all state holds, including the RAS. Control inputs are ignored.
- RAS operations occur only when adv & ~i_halt:
  - push = i_Jump & i_JAL.
  - pop = i_JALR & ~i_Jump.
- Push: write i_ret_addr at the top, count = min(count+1, RAS_DEPTH). If count was RAS_DEPTH, the oldest entry is overwritten (circular) and o_ras_overflow is set.
- Pop: if count>0, count-1 and the top pointer moves back. If count==0, this is a no-op and no error flag is raised.
- Push and pop together is impossible: push requires i_Jump, pop requires ~i_Jump.
- i_JAL without i_Jump is ignored.
- o_ras_top and o_ras_valid are registered-state views and reflect the stack after the edge.

Test Plan:
- Reset: RESET_PC=0x100, hold i_reset=0, pulse clk -> o_pc=0x100, o_adv_cnt=0, o_ras_valid=0. Assert i_reset=0 asynchronously mid-cycle after o_pc=0x120 -> o_pc=0x100 immediately, without a clock edge.
- Priority: i_enable=1, i_Jump=i_JALR=i_pcSrc=1, jump=0x400, rs=0x800, branch=0x200 -> o_pc=0x400. Drop i_Jump -> 0x800. Drop i_JALR -> 0x200. Drop all -> 0x204.
- Stall and step: i_stall=1 for 3 cycles -> o_pc and o_adv_cnt frozen. i_enable=0, then 1-cycle i_step pulses x2 -> o_pc advances by exactly 8 and o_adv_cnt by 2. i_step with i_stall=1 -> no change.
- Halt: at o_pc=0x10, i_halt=1 with adv -> o_pc stays 0x10 and o_halted=1. Further i_enable/i_Jump -> no change until reset.
- RAS: RAS_DEPTH=4, 5 JAL pushes of 0xA0..0xA4 -> o_ras_top=0xA4, o_ras_overflow=1. Then 4 JALR pops -> tops 0xA3, 0xA2, 0xA1, then valid=0. A 5th pop -> valid stays 0 and no other change.
- Wrap: o_pc=0xFFFFFFFC, sequential advance -> o_pc=0x0. Preload o_adv_cnt near max via a long run (or reduced-NBITS build) -> wraps to 0.
